// File: rtl/bidir_bus_pkg.sv
// Shared types and constants for the bidirectional-bus RAM.
// Bus ownership states and the length of the release gap.
package bidir_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_DRIVE = 2'd1,
    TURN     = 2'd2
  } state_t;

  localparam int         TURN_CYCLES = 1;
  localparam logic [1:0] TURN_LAST   = 2'(TURN_CYCLES - 1);

endpackage

// File: rtl/bidir_ram_core.sv
// Storage array with a synchronous write and a registered synchronous read.
// Contents are not reset; only the read register is.
module bidir_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port: array is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: loads on every accepted read, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem_r[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/bidir_bus_ram.sv
// Single-port RAM on a shared tristate bus: read FSM with a forced turnaround
// cycle and a sticky error flag for contention and illegal requests.
module bidir_bus_ram
  import bidir_bus_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] bus,
  output logic              rvalid,
  output logic              err,
  input  logic              err_clr
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        turn_cnt_r;
  logic              rvalid_r;
  logic              err_r;
  logic              wr_req_s;
  logic              rd_req_s;
  logic              we_s;
  logic              re_s;
  logic              err_set_s;
  logic [DATA_W-1:0] rdata_s;

  // Request decode and next-state selection.
  always_comb begin
    wr_req_s    = cs & wr;
    rd_req_s    = cs & rd;
    we_s        = 1'b0;
    re_s        = 1'b0;
    err_set_s   = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rd_req_s && wr_req_s) begin
          err_set_s = 1'b1;
        end else if (wr_req_s) begin
          we_s = 1'b1;
        end else if (rd_req_s) begin
          re_s        = 1'b1;
          state_nxt_s = RD_DRIVE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_DRIVE: begin
        // A write while we own the bus is contention: drop it and release.
        if (wr_req_s) begin
          err_set_s   = 1'b1;
          state_nxt_s = TURN;
        end else if (rd_req_s) begin
          re_s        = 1'b1;
          state_nxt_s = RD_DRIVE;
        end else begin
          state_nxt_s = TURN;
        end
      end
      TURN: begin
        err_set_s = wr_req_s;
        if (turn_cnt_r == TURN_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TURN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, drive-enable and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      turn_cnt_r <= 2'd0;
      rvalid_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rvalid_r <= (state_nxt_s == RD_DRIVE);
      if (state_r == TURN && state_nxt_s == TURN) begin
        turn_cnt_r <= turn_cnt_r + 2'd1;
      end else begin
        turn_cnt_r <= 2'd0;
      end
      // Set has priority over clear.
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  bidir_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we_s),
    .re   (re_s),
    .addr (addr),
    .wdata(bus),
    .rdata(rdata_s)
  );

  assign rvalid = rvalid_r;
  assign err    = err_r;
  assign bus    = rvalid_r ? rdata_s : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bidir_bus_ram.sv
// Table-driven bench for bidir_bus_ram with a read-data scoreboard.
module tb_bidir_bus_ram;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          cs      = 1'b0;
  logic          rd      = 1'b0;
  logic          wr      = 1'b0;
  logic          err_clr = 1'b0;
  logic [AW-1:0] addr    = '0;
  logic [DW-1:0] tb_data = '0;
  logic          tb_oe   = 1'b0;
  wire  [DW-1:0] bus;
  logic          rvalid;
  logic          err;

  assign bus = tb_oe ? tb_data : {DW{1'bz}};

  bidir_bus_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .bus(bus), .rvalid(rvalid), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cs, rd, wr, clr, drv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rd_acc, wr_acc, exp_rv, exp_err;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model[2**AW];
  logic [DW-1:0] sbq[$];
  int            checks = 0;
  int            passes = 0;

  function automatic void add(logic c, logic r, logic w, logic clr, logic drv,
                              logic [AW-1:0] a, logic [DW-1:0] d,
                              logic racc, logic wacc, logic rv, logic er);
    vec_t v;
    v.cs = c; v.rd = r; v.wr = w; v.clr = clr; v.drv = drv; v.a = a; v.d = d;
    v.rd_acc = racc; v.wr_acc = wacc; v.exp_rv = rv; v.exp_err = er;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(vec_t v, int idx);
    logic [DW-1:0] e;
    cs = v.cs; rd = v.rd; wr = v.wr; err_clr = v.clr;
    addr = v.a; tb_data = v.d; tb_oe = v.drv;
    if (v.rd_acc) sbq.push_back(model[v.a]);
    @(posedge clk);
    if (v.wr_acc) model[v.a] = v.d;
    #1;
    tb_oe = 1'b0;
    chk($sformatf("rvalid[%0d]", idx), {7'd0, rvalid}, {7'd0, v.exp_rv});
    chk($sformatf("err[%0d]", idx), {7'd0, err}, {7'd0, v.exp_err});
    if (rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_read[%0d]: got rvalid 1 expected no pending read", idx);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("bus[%0d]", idx), bus, e);
      end
    end
  endtask

  initial begin
    //  cs rd wr clr drv addr  data    racc wacc rv err
    add(1, 0, 1, 0, 1, 4'd3, 8'hA5,  0, 1, 0, 0);  // writes from IDLE, back to back
    add(1, 0, 1, 0, 1, 4'd4, 8'h5A,  0, 1, 0, 0);
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  1, 0, 1, 0);  // read addr 3
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);  // TURN
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);  // IDLE
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  1, 0, 1, 0);  // streaming 3,4,3
    add(1, 1, 0, 0, 0, 4'd4, 8'h00,  1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  1, 0, 1, 0);
    add(1, 0, 1, 0, 0, 4'd4, 8'hFF,  0, 0, 0, 1);  // contention -> TURN
    add(1, 0, 0, 1, 0, 4'd0, 8'h00,  0, 0, 0, 0);  // clear err, IDLE
    add(1, 1, 0, 0, 0, 4'd4, 8'h00,  1, 0, 1, 0);  // addr 4 unchanged
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(1, 1, 1, 0, 1, 4'd3, 8'h11,  0, 0, 0, 1);  // rd&wr in IDLE
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  1, 0, 1, 1);  // addr 3 unchanged
    add(0, 0, 0, 1, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'd4, 8'h00,  1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);  // TURN
    add(1, 0, 1, 0, 1, 4'd4, 8'h3C,  0, 0, 0, 1);  // write in TURN discarded
    add(1, 0, 1, 0, 1, 4'd4, 8'hC3,  0, 1, 0, 1);  // next-cycle write accepted
    add(1, 1, 0, 0, 0, 4'd4, 8'h00,  1, 0, 1, 1);  // reads C3
    add(0, 0, 0, 1, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(1, 1, 1, 1, 1, 4'd2, 8'h99,  0, 0, 0, 1);  // set beats clear
    add(0, 0, 0, 1, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);  // TURN
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  0, 0, 0, 0);  // rd in TURN ignored
    add(1, 1, 0, 0, 0, 4'd3, 8'h00,  1, 0, 1, 0);  // re-request accepted
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 4'd0, 8'h00,  0, 0, 0, 0);
    add(1, 0, 1, 0, 1, 4'd5, 8'h77,  0, 1, 0, 0);
    add(1, 1, 1, 0, 1, 4'd5, 8'h00,  0, 0, 0, 1);  // err set before reset
    add(1, 1, 0, 0, 0, 4'd5, 8'h00,  1, 0, 1, 1);  // read under way

    #12;
    chk("reset_rvalid", {7'd0, rvalid}, 8'd0);
    chk("reset_err", {7'd0, err}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-read: rd held, bus must release without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_rvalid", {7'd0, rvalid}, 8'd0);
    chk("midreset_err", {7'd0, err}, 8'd0);
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset_rvalid", {7'd0, rvalid}, 8'd0);
    sbq.delete();
    begin
      vec_t v;
      v.cs = 1; v.rd = 1; v.wr = 0; v.clr = 0; v.drv = 0; v.a = 4'd5; v.d = 8'h00;
      v.rd_acc = 1; v.wr_acc = 0; v.exp_rv = 1; v.exp_err = 0;
      apply(v, 100);
      v.cs = 0; v.rd = 0; v.a = 4'd0; v.rd_acc = 0; v.exp_rv = 0;
      apply(v, 101);
    end
    chk("scoreboard_empty", 8'(sbq.size()), 8'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
